// File: rtl/wb_port_arbiter_if.sv
// Writeback bus between the FU result slots and the PRF write / ROB finish ports.
// Per-FU fields are packed flat with FU i in slice i; per-port fields likewise with port j in slice j.
interface wb_port_arbiter_if #(
    parameter int NUM_FU    = 4,
    parameter int NUM_PORTS = 2,
    parameter int PRF_AW    = 7,
    parameter int ROB_IDW   = 6
);
    logic [NUM_FU-1:0]           fu_valid;
    logic [NUM_FU-1:0]           fu_ready;
    logic [NUM_FU-1:0]           fu_prf_we;
    logic [NUM_FU*PRF_AW-1:0]    fu_prf_addr;
    logic [NUM_FU*32-1:0]        fu_prf_data;
    logic [NUM_FU*ROB_IDW-1:0]   fu_rob_id;
    logic [NUM_FU-1:0]           fu_br_taken;
    logic [NUM_FU*32-1:0]        fu_br_addr;
    logic [NUM_FU-1:0]           fu_exc;
    logic [NUM_FU*5-1:0]         fu_exc_code;

    logic [NUM_PORTS-1:0]         wb_valid;
    logic [NUM_PORTS-1:0]         wb_prf_we;
    logic [NUM_PORTS*PRF_AW-1:0]  wb_prf_addr;
    logic [NUM_PORTS*32-1:0]      wb_prf_data;
    logic [NUM_PORTS*ROB_IDW-1:0] wb_rob_id;
    logic [NUM_PORTS-1:0]         wb_br_taken;
    logic [NUM_PORTS*32-1:0]      wb_br_addr;
    logic [NUM_PORTS-1:0]         wb_exc;
    logic [NUM_PORTS*5-1:0]       wb_exc_code;

    modport master (
        output fu_valid, fu_prf_we, fu_prf_addr, fu_prf_data, fu_rob_id,
               fu_br_taken, fu_br_addr, fu_exc, fu_exc_code,
        input  fu_ready,
        input  wb_valid, wb_prf_we, wb_prf_addr, wb_prf_data, wb_rob_id,
               wb_br_taken, wb_br_addr, wb_exc, wb_exc_code
    );

    modport slave (
        input  fu_valid, fu_prf_we, fu_prf_addr, fu_prf_data, fu_rob_id,
               fu_br_taken, fu_br_addr, fu_exc, fu_exc_code,
        output fu_ready,
        output wb_valid, wb_prf_we, wb_prf_addr, wb_prf_data, wb_rob_id,
               wb_br_taken, wb_br_addr, wb_exc, wb_exc_code
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares NUM_PORTS PRF-write/ROB-finish ports among NUM_FU one-entry result slots; WB_ARB_RR_EN selects round-robin over fixed priority.
// Latency: 2 cycles fu_valid -> wb_valid (slot register, then output register).
// Backpressure: fu_ready[i] drops while slot i is full and not granted this cycle; forced low in rst/flush.
module wb_port_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int NUM_PORTS = 2,
    parameter int PRF_AW    = 7,
    parameter int ROB_IDW   = 6
) (
    input logic              clk,
    input logic              rst,
    input logic              flush,
    wb_port_arbiter_if.slave bus
);
    localparam int IDXW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic               prf_we;
        logic [PRF_AW-1:0]  prf_addr;
        logic [31:0]        prf_data;
        logic [ROB_IDW-1:0] rob_id;
        logic               br_taken;
        logic [31:0]        br_addr;
        logic               exc;
        logic [4:0]         exc_code;
    } pkt_t;

    logic                 kill;
    pkt_t                 fu_pkt     [NUM_FU];
    pkt_t                 hold_pkt_q [NUM_FU];
    logic [NUM_FU-1:0]    hold_valid_q, hold_valid_d;
    logic [NUM_FU-1:0]    grant, ready, accept;
    logic [NUM_PORTS-1:0] port_vld, wb_valid_q;
    logic [IDXW-1:0]      port_idx   [NUM_PORTS];
    pkt_t                 wb_pkt_q   [NUM_PORTS];
`ifdef WB_ARB_RR_EN
    logic [IDXW-1:0]      rr_ptr_q, rr_ptr_d, last_idx;
`endif

    assign kill = rst | flush;

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            fu_pkt[i].prf_we   = bus.fu_prf_we[i];
            fu_pkt[i].prf_addr = bus.fu_prf_addr[i*PRF_AW +: PRF_AW];
            fu_pkt[i].prf_data = bus.fu_prf_data[i*32 +: 32];
            fu_pkt[i].rob_id   = bus.fu_rob_id[i*ROB_IDW +: ROB_IDW];
            fu_pkt[i].br_taken = bus.fu_br_taken[i];
            fu_pkt[i].br_addr  = bus.fu_br_addr[i*32 +: 32];
            fu_pkt[i].exc      = bus.fu_exc[i];
            fu_pkt[i].exc_code = bus.fu_exc_code[i*5 +: 5];
        end
    end

    // Scan looks only at registered slot state, so grant never depends on fu_valid.
    always_comb begin : grant_scan
        int              cnt;
        logic [IDXW-1:0] idx;
        cnt      = 0;
        idx      = '0;
        grant    = '0;
        port_vld = '0;
        for (int j = 0; j < NUM_PORTS; j++) port_idx[j] = '0;
`ifdef WB_ARB_RR_EN
        last_idx = rr_ptr_q;
`endif
        for (int k = 0; k < NUM_FU; k++) begin
`ifdef WB_ARB_RR_EN
            idx = IDXW'((int'(rr_ptr_q) + k) % NUM_FU);
`else
            idx = IDXW'(k);
`endif
            if (hold_valid_q[idx] && cnt < NUM_PORTS) begin
                grant[idx] = 1'b1;
                for (int j = 0; j < NUM_PORTS; j++) begin
                    if (j == cnt) begin
                        port_vld[j] = 1'b1;
                        port_idx[j] = idx;
                    end
                end
`ifdef WB_ARB_RR_EN
                last_idx = idx;
`endif
                cnt = cnt + 1;
            end
        end
    end

`ifdef WB_ARB_RR_EN
    assign rr_ptr_d = (int'(last_idx) == NUM_FU - 1) ? '0 : last_idx + IDXW'(1);
`endif

    assign ready        = kill ? '0 : (~hold_valid_q | grant);
    assign accept       = bus.fu_valid & ready;
    assign hold_valid_d = (hold_valid_q & ~grant) | accept;
    assign bus.fu_ready = ready;

    always_ff @(posedge clk) begin
        if (kill) begin
            hold_valid_q <= '0;
            wb_valid_q   <= '0;
            for (int j = 0; j < NUM_PORTS; j++) wb_pkt_q[j] <= '0;
`ifdef WB_ARB_RR_EN
            rr_ptr_q     <= '0;
`endif
        end else begin
            hold_valid_q <= hold_valid_d;
            wb_valid_q   <= port_vld;
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (port_vld[j]) wb_pkt_q[j] <= hold_pkt_q[port_idx[j]];
            end
`ifdef WB_ARB_RR_EN
            if (|grant) rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    // accept is already gated off by rst/flush, so the payload needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (accept[i]) hold_pkt_q[i] <= fu_pkt[i];
        end
    end

    assign bus.wb_valid = wb_valid_q;

    always_comb begin
        for (int j = 0; j < NUM_PORTS; j++) begin
            bus.wb_prf_we[j]                      = wb_pkt_q[j].prf_we;
            bus.wb_prf_addr[j*PRF_AW +: PRF_AW]   = wb_pkt_q[j].prf_addr;
            bus.wb_prf_data[j*32 +: 32]           = wb_pkt_q[j].prf_data;
            bus.wb_rob_id[j*ROB_IDW +: ROB_IDW]   = wb_pkt_q[j].rob_id;
            bus.wb_br_taken[j]                    = wb_pkt_q[j].br_taken;
            bus.wb_br_addr[j*32 +: 32]            = wb_pkt_q[j].br_addr;
            bus.wb_exc[j]                         = wb_pkt_q[j].exc;
            bus.wb_exc_code[j*5 +: 5]             = wb_pkt_q[j].exc_code;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised and directed bench for wb_port_arbiter against a slot/port reference model.
module tb_wb_port_arbiter;
    localparam int NF = 4;
    localparam int NP = 2;
    localparam int AW = 7;
    localparam int RW = 6;

    typedef struct packed {
        logic          prf_we;
        logic [AW-1:0] prf_addr;
        logic [31:0]   prf_data;
        logic [RW-1:0] rob_id;
        logic          br_taken;
        logic [31:0]   br_addr;
        logic          exc;
        logic [4:0]    exc_code;
    } pkt_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    wb_port_arbiter_if #(.NUM_FU(NF), .NUM_PORTS(NP), .PRF_AW(AW), .ROB_IDW(RW)) bus ();

    wb_port_arbiter #(.NUM_FU(NF), .NUM_PORTS(NP), .PRF_AW(AW), .ROB_IDW(RW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic          in_vld [NF];
    pkt_t          in_pkt [NF];
    logic          m_hv   [NF];
    pkt_t          m_hp   [NF];
    logic [NP-1:0] m_wv;
    pkt_t          m_wp   [NP];
    int            m_ptr;
    int            total;
    int            bad;

    function automatic pkt_t rand_pkt();
        pkt_t p;
        p.prf_we   = 1'($urandom_range(0, 1));
        p.prf_addr = AW'($urandom);
        p.prf_data = $urandom;
        p.rob_id   = RW'($urandom);
        p.br_taken = 1'($urandom_range(0, 1));
        p.br_addr  = $urandom;
        p.exc      = 1'($urandom_range(0, 1));
        p.exc_code = 5'($urandom);
        return p;
    endfunction

    // FU index visited at position k of this cycle's scan
    function automatic int scan_idx(int k);
`ifdef WB_ARB_RR_EN
        return (m_ptr + k) % NF;
`else
        return k;
`endif
    endfunction

    function automatic logic [NF-1:0] m_grant();
        logic [NF-1:0] g;
        int n;
        g = '0;
        n = 0;
        for (int k = 0; k < NF; k++) begin
            if (m_hv[scan_idx(k)] && n < NP) begin
                g[scan_idx(k)] = 1'b1;
                n++;
            end
        end
        return g;
    endfunction

    function automatic logic [NF-1:0] exp_ready();
        logic [NF-1:0] g;
        logic [NF-1:0] r;
        if (rst || flush) return '0;
        g = m_grant();
        for (int i = 0; i < NF; i++) r[i] = !m_hv[i] || g[i];
        return r;
    endfunction

    function automatic pkt_t dut_port(int j);
        pkt_t p;
        p.prf_we   = bus.wb_prf_we[j];
        p.prf_addr = bus.wb_prf_addr[j*AW +: AW];
        p.prf_data = bus.wb_prf_data[j*32 +: 32];
        p.rob_id   = bus.wb_rob_id[j*RW +: RW];
        p.br_taken = bus.wb_br_taken[j];
        p.br_addr  = bus.wb_br_addr[j*32 +: 32];
        p.exc      = bus.wb_exc[j];
        p.exc_code = bus.wb_exc_code[j*5 +: 5];
        return p;
    endfunction

    task automatic drive();
        for (int i = 0; i < NF; i++) begin
            bus.fu_valid[i]             = in_vld[i];
            bus.fu_prf_we[i]            = in_pkt[i].prf_we;
            bus.fu_prf_addr[i*AW +: AW] = in_pkt[i].prf_addr;
            bus.fu_prf_data[i*32 +: 32] = in_pkt[i].prf_data;
            bus.fu_rob_id[i*RW +: RW]   = in_pkt[i].rob_id;
            bus.fu_br_taken[i]          = in_pkt[i].br_taken;
            bus.fu_br_addr[i*32 +: 32]  = in_pkt[i].br_addr;
            bus.fu_exc[i]               = in_pkt[i].exc;
            bus.fu_exc_code[i*5 +: 5]   = in_pkt[i].exc_code;
        end
    endtask

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        int            gl[$];
        logic [NF-1:0] g;
        if (rst || flush) begin
            for (int i = 0; i < NF; i++) m_hv[i] = 1'b0;
            for (int j = 0; j < NP; j++) m_wp[j] = '0;
            m_wv  = '0;
            m_ptr = 0;
            return;
        end
        for (int k = 0; k < NF; k++)
            if (m_hv[scan_idx(k)] && gl.size() < NP) gl.push_back(scan_idx(k));
        g = '0;
        foreach (gl[q]) g[gl[q]] = 1'b1;
        for (int j = 0; j < NP; j++) begin
            if (j < gl.size()) begin
                m_wv[j] = 1'b1;
                m_wp[j] = m_hp[gl[j]];
            end else begin
                m_wv[j] = 1'b0;
            end
        end
        for (int i = 0; i < NF; i++) begin
            if (in_vld[i] && (!m_hv[i] || g[i])) begin
                m_hv[i] = 1'b1;
                m_hp[i] = in_pkt[i];
            end else if (g[i]) begin
                m_hv[i] = 1'b0;
            end
        end
        if (gl.size() > 0) m_ptr = (gl[gl.size()-1] + 1) % NF;
    endtask

    task automatic tick();
        drive();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NF; i++) in_vld[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        flush = 1'b0;
        for (int i = 0; i < NF; i++) begin
            in_vld[i] = 1'b1;
            in_pkt[i] = rand_pkt();
        end
        drive();
        #1;
        total++;
        if (bus.fu_ready !== 4'h0) begin bad++; $display("FAIL reset_ready got=%b want=0000", bus.fu_ready); end
        tick();
        tick();
        total++;
        if (bus.wb_valid !== 2'b00 || bus.wb_prf_data !== 64'h0 || bus.wb_prf_addr !== 14'h0 ||
            bus.wb_rob_id !== 12'h0 || bus.wb_br_addr !== 64'h0 || bus.wb_exc_code !== 10'h0 ||
            bus.wb_prf_we !== 2'b00 || bus.wb_br_taken !== 2'b00 || bus.wb_exc !== 2'b00) begin
            bad++;
            $display("FAIL reset_outputs got vld=%b data=%h addr=%h want all zero", bus.wb_valid, bus.wb_prf_data, bus.wb_prf_addr);
        end
        rst = 1'b0;
        idle_inputs();
        drive();
        #1;
        total++;
        if (bus.fu_ready !== 4'hF) begin bad++; $display("FAIL reset_release_ready got=%b want=1111", bus.fu_ready); end
    endtask

    task automatic test_four_at_once();
        for (int i = 0; i < NF; i++) begin
            in_vld[i]          = 1'b1;
            in_pkt[i]          = rand_pkt();
            in_pkt[i].prf_addr = AW'(10 + i);
        end
        tick();
        idle_inputs();
        drive();
        #1;
        total++;
        if (bus.fu_ready !== 4'b0011) begin bad++; $display("FAIL four_ready_between got=%b want=0011", bus.fu_ready); end
        tick();
        total++;
        if (bus.wb_valid !== 2'b11 || bus.wb_prf_addr[6:0] !== 7'd10 || bus.wb_prf_addr[13:7] !== 7'd11) begin
            bad++;
            $display("FAIL four_first_pair got vld=%b a0=%0d a1=%0d want 11/10/11", bus.wb_valid, bus.wb_prf_addr[6:0], bus.wb_prf_addr[13:7]);
        end
        tick();
        total++;
        if (bus.wb_valid !== 2'b11 || bus.wb_prf_addr[6:0] !== 7'd12 || bus.wb_prf_addr[13:7] !== 7'd13) begin
            bad++;
            $display("FAIL four_second_pair got vld=%b a0=%0d a1=%0d want 11/12/13", bus.wb_valid, bus.wb_prf_addr[6:0], bus.wb_prf_addr[13:7]);
        end
        total++;
        if (dut_port(0) !== m_wp[0] || dut_port(1) !== m_wp[1]) begin
            bad++;
            $display("FAIL four_fields got p0=%h p1=%h want p0=%h p1=%h", dut_port(0), dut_port(1), m_wp[0], m_wp[1]);
        end
        tick();
        total++;
        if (bus.wb_valid !== 2'b00) begin bad++; $display("FAIL four_drained got=%b want=00", bus.wb_valid); end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        for (int c = 0; c < 7; c++) begin
            if (c < 5) begin
                in_vld[1]          = 1'b1;
                in_pkt[1]          = rand_pkt();
                in_pkt[1].prf_data = 32'(c + 1);
            end else begin
                in_vld[1] = 1'b0;
            end
            drive();
            #1;
            if (c < 5) begin
                total++;
                if (bus.fu_ready[1] !== 1'b1) begin bad++; $display("FAIL b2b_ready c=%0d got=%b want=1", c, bus.fu_ready[1]); end
            end
            tick();
            if (c >= 1 && c <= 5) begin
                total++;
                if (bus.wb_valid !== 2'b01 || bus.wb_prf_data[31:0] !== 32'(c)) begin
                    bad++;
                    $display("FAIL b2b_data c=%0d got vld=%b data=%0d want 01/%0d", c, bus.wb_valid, bus.wb_prf_data[31:0], c);
                end
            end
        end
        total++;
        if (bus.wb_valid !== 2'b00) begin bad++; $display("FAIL b2b_tail got=%b want=00", bus.wb_valid); end
    endtask

    task automatic test_contention();
        int lo;
        flush = 1'b1;
        idle_inputs();
        tick();
        flush = 1'b0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < NF; i++) begin
                in_vld[i]          = 1'b1;
                in_pkt[i]          = rand_pkt();
                in_pkt[i].prf_addr = AW'(20 + i);
            end
            drive();
            #1;
            if (c >= 1) begin
                total++;
                if (bus.fu_ready !== exp_ready()) begin bad++; $display("FAIL cont_ready c=%0d got=%b want=%b", c, bus.fu_ready, exp_ready()); end
`ifndef WB_ARB_RR_EN
                total++;
                if (bus.fu_ready[3:2] !== 2'b00) begin bad++; $display("FAIL cont_starve c=%0d got=%b want=00", c, bus.fu_ready[3:2]); end
`endif
            end
            tick();
            if (c >= 1) begin
`ifdef WB_ARB_RR_EN
                lo = ((c - 1) % 2 == 1) ? 2 : 0;
`else
                lo = 0;
`endif
                total++;
                if (bus.wb_valid !== 2'b11 || int'(bus.wb_prf_addr[6:0]) != 20 + lo || int'(bus.wb_prf_addr[13:7]) != 21 + lo) begin
                    bad++;
                    $display("FAIL cont_grant r=%0d got vld=%b a0=%0d a1=%0d want fu %0d,%0d", c - 1, bus.wb_valid, bus.wb_prf_addr[6:0], bus.wb_prf_addr[13:7], lo, lo + 1);
                end
            end
        end
        idle_inputs();
        tick();
`ifdef WB_ARB_RR_EN
        lo = 2;
`else
        lo = 0;
`endif
        total++;
        if (bus.wb_valid !== 2'b11 || int'(bus.wb_prf_addr[6:0]) != 20 + lo || int'(bus.wb_prf_addr[13:7]) != 21 + lo) begin
            bad++;
            $display("FAIL cont_grant r=3 got vld=%b a0=%0d a1=%0d want fu %0d,%0d", bus.wb_valid, bus.wb_prf_addr[6:0], bus.wb_prf_addr[13:7], lo, lo + 1);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (bus.wb_valid !== m_wv || (m_wv[0] && dut_port(0) !== m_wp[0]) || (m_wv[1] && dut_port(1) !== m_wp[1])) begin
                bad++;
                $display("FAIL cont_drain c=%0d got vld=%b want=%b", c, bus.wb_valid, m_wv);
            end
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        in_vld[2] = 1'b1; in_pkt[2] = rand_pkt();
        in_vld[3] = 1'b1; in_pkt[3] = rand_pkt();
        tick();
        idle_inputs();
        in_vld[0] = 1'b1;
        in_pkt[0] = rand_pkt();
        flush     = 1'b1;
        drive();
        #1;
        total++;
        if (bus.fu_ready !== 4'h0) begin bad++; $display("FAIL flush_ready got=%b want=0000", bus.fu_ready); end
        tick();
        total++;
        if (bus.wb_valid !== 2'b00 || bus.wb_prf_data !== 64'h0 || bus.wb_rob_id !== 12'h0) begin
            bad++;
            $display("FAIL flush_outputs got vld=%b data=%h rob=%h want zero", bus.wb_valid, bus.wb_prf_data, bus.wb_rob_id);
        end
        flush = 1'b0;
        idle_inputs();
        drive();
        #1;
        total++;
        if (bus.fu_ready !== 4'hF) begin bad++; $display("FAIL flush_release_ready got=%b want=1111", bus.fu_ready); end
        tick();
        total++;
        if (bus.wb_valid !== 2'b00) begin bad++; $display("FAIL flush_no_emit got=%b want=00", bus.wb_valid); end
    endtask

    task automatic test_fields();
        pkt_t p;
        p          = rand_pkt();
        p.rob_id   = 6'h2A;
        p.br_taken = 1'b1;
        p.exc      = 1'b1;
        p.exc_code = 5'h04;
        idle_inputs();
        in_vld[3] = 1'b1;
        in_pkt[3] = p;
        tick();
        idle_inputs();
        tick();
        total++;
        if (bus.wb_valid !== 2'b01 || bus.wb_rob_id[5:0] !== 6'h2A || bus.wb_br_taken[0] !== 1'b1 ||
            bus.wb_exc[0] !== 1'b1 || bus.wb_exc_code[4:0] !== 5'h04) begin
            bad++;
            $display("FAIL fields_fixed got vld=%b rob=%h bt=%b exc=%b code=%h want 01/2a/1/1/04",
                     bus.wb_valid, bus.wb_rob_id[5:0], bus.wb_br_taken[0], bus.wb_exc[0], bus.wb_exc_code[4:0]);
        end
        total++;
        if (dut_port(0) !== p) begin bad++; $display("FAIL fields_all got=%h want=%h", dut_port(0), p); end
        tick();
    endtask

    task automatic test_rst_midflight();
        for (int i = 0; i < NF; i++) begin
            in_vld[i] = 1'b1;
            in_pkt[i] = rand_pkt();
        end
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive();
        #1;
        total++;
        if (bus.wb_valid !== 2'b00 || bus.wb_prf_addr !== 14'h0 || bus.wb_prf_data !== 64'h0 ||
            bus.wb_br_addr !== 64'h0 || bus.wb_exc !== 2'b00) begin
            bad++;
            $display("FAIL rst_pulse_outputs got vld=%b addr=%h data=%h want zero", bus.wb_valid, bus.wb_prf_addr, bus.wb_prf_data);
        end
        total++;
        if (bus.fu_ready !== 4'hF) begin bad++; $display("FAIL rst_pulse_ready got=%b want=1111", bus.fu_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (bus.wb_valid !== 2'b00) begin bad++; $display("FAIL rst_stale c=%0d got=%b want=00", c, bus.wb_valid); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NF; i++) begin
                in_vld[i] = 1'($urandom_range(0, 1));
                in_pkt[i] = rand_pkt();
            end
            flush = ($urandom_range(0, 31) == 0);
            drive();
            #1;
            total++;
            if (bus.fu_ready !== exp_ready()) begin bad++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, bus.fu_ready, exp_ready()); end
            tick();
            total++;
            if (bus.wb_valid !== m_wv) begin bad++; $display("FAIL rand_valid c=%0d got=%b want=%b", c, bus.wb_valid, m_wv); end
            for (int j = 0; j < NP; j++) begin
                if (m_wv[j]) begin
                    total++;
                    if (dut_port(j) !== m_wp[j]) begin bad++; $display("FAIL rand_port%0d c=%0d got=%h want=%h", j, c, dut_port(j), m_wp[j]); end
                end
            end
        end
        flush = 1'b0;
        idle_inputs();
        for (int c = 0; c < 4; c++) tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_wv  = '0;
        m_ptr = 0;
        for (int i = 0; i < NF; i++) begin
            m_hv[i]   = 1'b0;
            m_hp[i]   = '0;
            in_vld[i] = 1'b0;
            in_pkt[i] = '0;
        end
        for (int j = 0; j < NP; j++) m_wp[j] = '0;
        test_reset();
        test_four_at_once();
        test_back_to_back();
        test_contention();
        test_flush();
        test_fields();
        test_rst_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
